// File: rtl/line_trigger_scheduler_pkg.sv
// Shared types and constants for the line trigger scheduler slice.
package line_trigger_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam int unsigned PD_A_IDX   = 0;
    localparam int unsigned PD_B_IDX   = 1;
    localparam int unsigned POS_W_DEF  = 32;
    localparam int unsigned LINE_W_DEF = 16;
    localparam int unsigned BL_W       = 16;
    localparam int unsigned SKIP_W     = 16;

endpackage

// File: rtl/line_trigger_scheduler_backlash_filter.sv
// Absorbs reverse travel: forward pulses first pay back the reverse count
// before any of them is reported as an effective pulse.
module backlash_filter
    import line_trigger_scheduler_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            fwd_i,
    input  logic            rev_i,
    output logic            eff_o,
    output logic [BL_W-1:0] bl_cnt_o
);

    logic [BL_W-1:0] bl_q, bl_d;

    always_comb begin
        bl_d = bl_q;
        if (clr_i) begin
            bl_d = '0;
        end else if (en_i) begin
            if (rev_i && (bl_q != '1)) begin
                bl_d = bl_q + BL_W'(1);
            end else if (fwd_i && (bl_q != '0)) begin
                bl_d = bl_q - BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bl_q <= '0;
        end else begin
            bl_q <= bl_d;
        end
    end

    assign eff_o    = en_i && !clr_i && fwd_i && !rev_i && (bl_q == '0);
    assign bl_cnt_o = bl_q;

endmodule

// File: rtl/line_trigger_scheduler.sv
// Line-scan sequencer: tracks encoder position, waits a run-in distance and
// issues one line trigger per effective forward pulse, logging overruns.
module line_trigger_scheduler
    import line_trigger_scheduler_pkg::*;
#(
    parameter int unsigned POS_W  = POS_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [1:0]        PULSE_DIR,
    input  logic              DIR_SEL,
    input  logic              START,
    input  logic              ABORT,
    input  logic [SKIP_W-1:0] SKIP_PULSES,
    input  logic [LINE_W-1:0] LINES_NUM,
    input  logic              ACQ_BUSY,
    output logic              LINE_TRIG,
    output logic [LINE_W-1:0] LINE_IDX,
    output logic [POS_W-1:0]  POSITION,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERRUN,
    output logic [LINE_W-1:0] MISSED_CNT
);

    state_t state_q, state_d;

    logic              dir_sel_q;
    logic [SKIP_W-1:0] skip_cfg_q, skip_cnt_q;
    logic [LINE_W-1:0] lines_q, slot_q, line_idx_q, missed_q;
    logic [POS_W-1:0]  pos_q;
    logic              trig_q, done_q, ovr_q;

    logic pa, pb, pvalid, fwd, rev;
    logic start_acc, bl_en, eff;
    logic arm_hit, slot_take, last_slot;

    // Both direction bits together is treated as a glitch and dropped entirely.
    assign pa     = PULSE_DIR[PD_A_IDX];
    assign pb     = PULSE_DIR[PD_B_IDX];
    assign pvalid = pa ^ pb;
    assign fwd    = pvalid && (dir_sel_q ? pb : pa);
    assign rev    = pvalid && (dir_sel_q ? pa : pb);

    assign start_acc = START && !ABORT && (state_q == ST_IDLE);
    assign bl_en     = (state_q == ST_ARM) || (state_q == ST_SCAN);

    backlash_filter u_backlash (
        .clk_i    (CLK),
        .rst_n_i  (RST_N),
        .clr_i    (start_acc),
        .en_i     (bl_en),
        .fwd_i    (fwd),
        .rev_i    (rev),
        .eff_o    (eff),
        .bl_cnt_o ()
    );

    assign arm_hit   = (state_q == ST_ARM) && eff && !ABORT &&
                       ((skip_cnt_q + SKIP_W'(1)) == skip_cfg_q);
    // done_q holds SCAN one extra cycle so BUSY drops after DONE; no slots then.
    assign slot_take = (state_q == ST_SCAN) && eff && !ABORT && !done_q;
    assign last_slot = slot_take && (lines_q != '0) &&
                       (slot_q == (lines_q - LINE_W'(1)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_acc) state_d = (SKIP_PULSES == '0) ? ST_SCAN : ST_ARM;
            ST_ARM:  if (arm_hit)   state_d = ST_SCAN;
            ST_SCAN: if (done_q)    state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
        if (ABORT) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            dir_sel_q  <= 1'b0;
            skip_cfg_q <= '0;
            skip_cnt_q <= '0;
            lines_q    <= '0;
            slot_q     <= '0;
            line_idx_q <= '0;
            missed_q   <= '0;
            pos_q      <= '0;
            trig_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;

            if (start_acc) begin
                pos_q <= '0;
            end else if (fwd) begin
                pos_q <= pos_q + POS_W'(1);
            end else if (rev) begin
                pos_q <= pos_q - POS_W'(1);
            end

            if (start_acc) begin
                dir_sel_q  <= DIR_SEL;
                skip_cfg_q <= SKIP_PULSES;
                lines_q    <= LINES_NUM;
                skip_cnt_q <= '0;
                slot_q     <= '0;
                line_idx_q <= '0;
                missed_q   <= '0;
                ovr_q      <= 1'b0;
            end

            if ((state_q == ST_ARM) && eff && !ABORT) begin
                skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
            end

            if (slot_take) begin
                line_idx_q <= slot_q;
                slot_q     <= slot_q + LINE_W'(1);
                done_q     <= last_slot;
                if (!ACQ_BUSY) begin
                    trig_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                    if (missed_q != '1) missed_q <= missed_q + LINE_W'(1);
                end
            end
        end
    end

    assign LINE_TRIG  = trig_q;
    assign LINE_IDX   = line_idx_q;
    assign POSITION   = pos_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = done_q;
    assign OVERRUN    = ovr_q;
    assign MISSED_CNT = missed_q;

endmodule

// File: tb/tb_line_trigger_scheduler.sv
// Directed self-checking bench for line_trigger_scheduler.
module tb_line_trigger_scheduler;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  PULSE_DIR;
    logic        DIR_SEL;
    logic        START;
    logic        ABORT;
    logic [15:0] SKIP_PULSES;
    logic [15:0] LINES_NUM;
    logic        ACQ_BUSY;
    logic        LINE_TRIG;
    logic [15:0] LINE_IDX;
    logic [31:0] POSITION;
    logic        BUSY;
    logic        DONE;
    logic        OVERRUN;
    logic [15:0] MISSED_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    line_trigger_scheduler #(.POS_W(32), .LINE_W(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PULSE_DIR  (PULSE_DIR),
        .DIR_SEL    (DIR_SEL),
        .START      (START),
        .ABORT      (ABORT),
        .SKIP_PULSES(SKIP_PULSES),
        .LINES_NUM  (LINES_NUM),
        .ACQ_BUSY   (ACQ_BUSY),
        .LINE_TRIG  (LINE_TRIG),
        .LINE_IDX   (LINE_IDX),
        .POSITION   (POSITION),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OVERRUN    (OVERRUN),
        .MISSED_CNT (MISSED_CNT)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [1:0] pd, input logic st, input logic ab, input logic bz);
        PULSE_DIR = pd;
        START     = st;
        ABORT     = ab;
        ACQ_BUSY  = bz;
        @(posedge CLK);
        #1;
        PULSE_DIR = 2'b00;
        START     = 1'b0;
        ABORT     = 1'b0;
        ACQ_BUSY  = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; PULSE_DIR = 2'b00; DIR_SEL = 1'b0; START = 1'b0; ABORT = 1'b0;
        SKIP_PULSES = '0; LINES_NUM = '0; ACQ_BUSY = 1'b0;
        #12;
        chk("rst_trig", 32'(LINE_TRIG), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_pos",  POSITION, 32'd0);
        chk("rst_idx",  32'(LINE_IDX), 32'd0);
        RST_N = 1'b1;

        // Basic scan: skip 2, three lines, five forward pulses
        DIR_SEL = 1'b0; SKIP_PULSES = 16'd2; LINES_NUM = 16'd3;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        chk("b_busy_start", 32'(BUSY), 32'd1);
        chk("b_pos_start",  POSITION, 32'd0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("b_skip1_trig", 32'(LINE_TRIG), 32'd0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("b_skip2_trig", 32'(LINE_TRIG), 32'd0);
        chk("b_skip2_pos",  POSITION, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 1'b0, 1'b0, 1'b0);
            chk("b_trig", 32'(LINE_TRIG), 32'd1);
            chk("b_idx",  32'(LINE_IDX), 32'(i));
            chk("b_done", 32'(DONE), (i == 2) ? 32'd1 : 32'd0);
        end
        chk("b_pos_end",  POSITION, 32'd5);
        chk("b_busy_end", 32'(BUSY), 32'd1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        chk("b_busy_drop", 32'(BUSY), 32'd0);
        chk("b_done_pulse", 32'(DONE), 32'd0);

        // Backlash: 3 reverse then 5 forward in continuous scan
        SKIP_PULSES = 16'd0; LINES_NUM = 16'd0;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        chk("bl_pos_clr", POSITION, 32'd0);
        for (int i = 0; i < 3; i++) step(2'b10, 1'b0, 1'b0, 1'b0);
        chk("bl_pos_neg", POSITION, 32'hFFFF_FFFD);
        chk("bl_rev_trig", 32'(LINE_TRIG), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(2'b01, 1'b0, 1'b0, 1'b0);
            chk("bl_fwd_trig", 32'(LINE_TRIG), (i >= 3) ? 32'd1 : 32'd0);
        end
        chk("bl_idx", 32'(LINE_IDX), 32'd1);
        chk("bl_pos", POSITION, 32'd2);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        chk("bl_abort_busy", 32'(BUSY), 32'd0);
        chk("bl_abort_done", 32'(DONE), 32'd0);
        chk("bl_abort_idx",  32'(LINE_IDX), 32'd1);

        // Overrun: second line missed while acquisition busy
        LINES_NUM = 16'd4;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        chk("ov_idx_clr", 32'(LINE_IDX), 32'd0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("ov_t0", 32'(LINE_TRIG), 32'd1);
        chk("ov_ovr0", 32'(OVERRUN), 32'd0);
        step(2'b01, 1'b0, 1'b0, 1'b1);
        chk("ov_t1", 32'(LINE_TRIG), 32'd0);
        chk("ov_idx1", 32'(LINE_IDX), 32'd1);
        chk("ov_ovr1", 32'(OVERRUN), 32'd1);
        chk("ov_miss1", 32'(MISSED_CNT), 32'd1);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("ov_t2", 32'(LINE_TRIG), 32'd1);
        chk("ov_idx2", 32'(LINE_IDX), 32'd2);
        chk("ov_done2", 32'(DONE), 32'd0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("ov_t3", 32'(LINE_TRIG), 32'd1);
        chk("ov_idx3", 32'(LINE_IDX), 32'd3);
        chk("ov_done3", 32'(DONE), 32'd1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        chk("ov_busy_end", 32'(BUSY), 32'd0);
        chk("ov_ovr_hold", 32'(OVERRUN), 32'd1);
        chk("ov_miss_hold", 32'(MISSED_CNT), 32'd1);

        // Abort during ARM, START+ABORT collision, START while busy
        SKIP_PULSES = 16'd5; LINES_NUM = 16'd2;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        chk("ab_ovr_clr", 32'(OVERRUN), 32'd0);
        chk("ab_miss_clr", 32'(MISSED_CNT), 32'd0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("ab_arm_trig", 32'(LINE_TRIG), 32'd0);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        chk("ab_busy", 32'(BUSY), 32'd0);
        chk("ab_done", 32'(DONE), 32'd0);
        step(2'b00, 1'b1, 1'b1, 1'b0);
        chk("ab_collide_busy", 32'(BUSY), 32'd0);
        SKIP_PULSES = 16'd1;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("ab_skip_trig", 32'(LINE_TRIG), 32'd0);
        SKIP_PULSES = 16'd3;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        chk("ab_restart_pos", POSITION, 32'd1);
        chk("ab_restart_busy", 32'(BUSY), 32'd1);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("ab_restart_trig", 32'(LINE_TRIG), 32'd1);
        chk("ab_restart_idx", 32'(LINE_IDX), 32'd0);
        step(2'b00, 1'b0, 1'b1, 1'b0);

        // Continuous, no skip, B-leads forward
        DIR_SEL = 1'b1; SKIP_PULSES = 16'd0; LINES_NUM = 16'd0;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        DIR_SEL = 1'b0;
        step(2'b10, 1'b0, 1'b0, 1'b0);
        chk("c_t0", 32'(LINE_TRIG), 32'd1);
        chk("c_pos1", POSITION, 32'd1);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("c_rev_pos", POSITION, 32'd0);
        step(2'b11, 1'b0, 1'b0, 1'b0);
        chk("c_both_trig", 32'(LINE_TRIG), 32'd0);
        chk("c_both_pos", POSITION, 32'd0);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        chk("c_absorb_trig", 32'(LINE_TRIG), 32'd0);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        chk("c_t1", 32'(LINE_TRIG), 32'd1);
        chk("c_idx1", 32'(LINE_IDX), 32'd1);
        chk("c_pos2", POSITION, 32'd2);
        chk("c_nodone", 32'(DONE), 32'd0);
        step(2'b10, 1'b0, 1'b0, 1'b1);
        chk("c_miss", 32'(MISSED_CNT), 32'd1);

        // Asynchronous reset mid-scan, then a fresh scan
        #2 RST_N = 1'b0;
        #1;
        chk("r_ovr", 32'(OVERRUN), 32'd0);
        chk("r_miss", 32'(MISSED_CNT), 32'd0);
        chk("r_pos", POSITION, 32'd0);
        chk("r_idx", 32'(LINE_IDX), 32'd0);
        chk("r_busy", 32'(BUSY), 32'd0);
        #2 RST_N = 1'b1;
        LINES_NUM = 16'd1;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        chk("r2_busy", 32'(BUSY), 32'd1);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("r2_trig", 32'(LINE_TRIG), 32'd1);
        chk("r2_done", 32'(DONE), 32'd1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        chk("r2_idle", 32'(BUSY), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
